// File: rtl/load_unit.sv
// Load unit: one aligned word read per load, byte/half/word lane extraction with sign/zero extension.
// Latency: accept -> load_valid in 2 cycles minimum; a missing response times out after MAX_WAIT cycles.
// Backpressure: ld_ready only in IDLE, stall held while busy; LOAD_MISALIGN_CHK_EN traps misaligned half/word.
`ifndef MEM_READ
`define MEM_READ  2'b01
`endif
`ifndef MEM_WRITE
`define MEM_WRITE 2'b10
`endif
`ifndef MEM_BYTE
`define MEM_BYTE  2'b00
`endif
`ifndef MEM_HALF
`define MEM_HALF  2'b01
`endif
`ifndef MEM_WORD
`define MEM_WORD  2'b10
`endif

module load_unit #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_valid,
    input  logic [4:0]  mem_op,
    input  logic [31:0] addr,
    input  logic        flush,
    output logic        ld_ready,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        load_err
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;
    logic          err_q, err_d;

    logic          accept;
    logic          misalign;
    logic          timeout;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   rdata_ext;

    assign accept  = ld_valid && (mem_op[4:3] == `MEM_READ) && !flush;
    // Last wait cycle: the counter would reach MAX_WAIT if no data arrives now.
    assign timeout = (cnt_q == CW'(MAX_WAIT - 1));

`ifdef LOAD_MISALIGN_CHK_EN
    assign misalign = ((mem_op[1:0] == `MEM_HALF) && addr[0]) ||
                      ((mem_op[1:0] != `MEM_BYTE) && (mem_op[1:0] != `MEM_HALF) && (addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (addr_q[1:0])
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            2'd3:    byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            `MEM_BYTE: rdata_ext = {{24{byte_sel[7] & ~uns_q}}, byte_sel};
            `MEM_HALF: rdata_ext = {{16{half_sel[15] & ~uns_q}}, half_sel};
            default:   rdata_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d = addr;
                    size_d = mem_op[1:0];
                    uns_d  = mem_op[2];
                    cnt_d  = '0;
                    if (misalign) begin
                        state_d = S_RESP;
                        data_d  = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (flush) begin
                    // A response landing with the flush closes the transaction outright.
                    state_d = (mem_rvalid || timeout) ? S_IDLE : S_DRAIN;
                    cnt_d   = cnt_q + CW'(1);
                end else if (mem_rvalid) begin
                    state_d = S_RESP;
                    data_d  = rdata_ext;
                    err_d   = 1'b0;
                end else if (timeout) begin
                    state_d = S_RESP;
                    data_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: state_d = S_IDLE;
            S_DRAIN: begin
                if (mem_rvalid || timeout) state_d = S_IDLE;
                else                       cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ld_ready   = (state_q == S_IDLE);
        stall      = (state_q != S_IDLE) || accept;
        mem_req    = (state_q == S_WAIT) || (state_q == S_DRAIN);
        load_valid = (state_q == S_RESP) && !flush;
    end

    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign load_data = data_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_load_unit.sv
// Testbench for load_unit: directed vector table, hand sequences for flush/reset, and random loads
// checked against a transaction-level reference model.
module tb_load_unit;
    localparam int MW = 15;
    localparam logic [1:0] CL_RD = 2'b01, CL_WR = 2'b10;
    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid;
    logic [4:0]  mem_op;
    logic [31:0] addr;
    logic        flush;
    logic        ld_ready, stall, mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_err;

    int nvec  = 0;
    int nfail = 0;

    load_unit #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .mem_op(mem_op), .addr(addr),
        .flush(flush), .ld_ready(ld_ready), .stall(stall), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .load_valid(load_valid), .load_data(load_data), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] rd;
        int          dly;
        logic [31:0] exp_d;
        logic        exp_e;
        int          exp_lat;
        logic        exp_req;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference: value of the loaded datum from size/sign rules using plain arithmetic.
    function automatic logic [31:0] ref_extract(input logic [1:0] sz, input logic uns,
                                                input logic [31:0] a, input logic [31:0] rd);
        longint v;
        int lane;
        lane = int'(a[1:0]);
        if (sz == SZ_B) begin
            v = (longint'(rd) >> (8 * lane)) % 256;
            if (!uns && v >= 128) v = v - 256;
        end else if (sz == SZ_H) begin
            v = (longint'(rd) >> (16 * (lane / 2))) % 65536;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(rd);
        end
        return v[31:0];
    endfunction

    function automatic logic ref_misalign(input logic [1:0] sz, input logic [31:0] a);
`ifdef LOAD_MISALIGN_CHK_EN
        if (sz == SZ_H) return (a % 2) != 0;
        if (sz == SZ_W) return (a % 4) != 0;
        return 1'b0;
`else
        return (sz == 2'b11) && (a === 32'hx);
`endif
    endfunction

    task automatic run_load(input logic [4:0] op, input logic [31:0] a, input logic [31:0] rd,
                            input int dly, output int lat, output logic [31:0] dat,
                            output logic err, output logic req1, output logic [31:0] addr1);
        lat = -1; dat = '0; err = 1'b0; req1 = 1'b0; addr1 = '0;
        next_cycle();
        ld_valid = 1'b1; mem_op = op; addr = a; flush = 1'b0; mem_rvalid = 1'b0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            next_cycle();
            ld_valid   = 1'b0;
            mem_rvalid = (k - 1 == dly);
            mem_rdata  = mem_rvalid ? rd : $urandom;
            @(negedge clk);
            if (k == 1) begin
                req1  = mem_req;
                addr1 = mem_addr;
            end
            if (load_valid) begin
                lat = k; dat = load_data; err = load_err;
            end
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic apply(input string tag, input vec_t v);
        int lat; logic [31:0] dat; logic err; logic req1; logic [31:0] addr1;
        run_load(v.op, v.a, v.rd, v.dly, lat, dat, err, req1, addr1);
        check({tag, ".lat"}, lat, v.exp_lat);
        check({tag, ".data"}, dat, v.exp_d);
        check({tag, ".err"}, {31'b0, err}, {31'b0, v.exp_e});
        check({tag, ".req"}, {31'b0, req1}, {31'b0, v.exp_req});
        if (v.exp_req) check({tag, ".mem_addr"}, addr1, {v.a[31:2], 2'b00});
        next_cycle();
        @(negedge clk);
        check({tag, ".req_after"}, {31'b0, mem_req}, 32'd0);
        check({tag, ".ready_after"}, {31'b0, ld_ready}, 32'd1);
    endtask

    initial begin
        logic saw_valid;
        vec_t rv;
        logic [1:0] sz;
        logic uns;

        tbl[0] = '{{CL_RD, 1'b0, SZ_B}, 32'h103, 32'h80FF_1234, 0, 32'hFFFF_FF80, 1'b0, 2, 1'b1};
        tbl[1] = '{{CL_RD, 1'b1, SZ_H}, 32'h202, 32'h8001_7FFF, 0, 32'h0000_8001, 1'b0, 2, 1'b1};
        tbl[2] = '{{CL_RD, 1'b0, SZ_W}, 32'h400, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 1'b0, 5, 1'b1};
        tbl[3] = '{{CL_RD, 1'b1, SZ_B}, 32'h101, 32'h80FF_1234, 1, 32'h0000_0012, 1'b0, 3, 1'b1};
        tbl[4] = '{{CL_RD, 1'b0, SZ_H}, 32'h200, 32'h1234_F00D, 2, 32'hFFFF_F00D, 1'b0, 4, 1'b1};
        tbl[5] = '{{CL_RD, 1'b0, SZ_W}, 32'h600, 32'h1234_5678, MW, 32'h0, 1'b1, MW + 1, 1'b1};
        tbl[6] = '{{CL_RD, 1'b0, SZ_W}, 32'h604, 32'hCAFE_F00D, MW - 1, 32'hCAFE_F00D, 1'b0, MW + 1, 1'b1};
        tbl[7] = '{{CL_RD, 1'b0, SZ_B}, 32'h002, 32'h007F_0000, 0, 32'h0000_007F, 1'b0, 2, 1'b1};
`ifdef LOAD_MISALIGN_CHK_EN
        tbl[8] = '{{CL_RD, 1'b0, SZ_H}, 32'h301, 32'hAAAA_5555, 0, 32'h0, 1'b1, 1, 1'b0};
`else
        tbl[8] = '{{CL_RD, 1'b0, SZ_H}, 32'h301, 32'hAAAA_5555, 0, 32'h0000_5555, 1'b0, 2, 1'b1};
`endif

        rst_n = 1'b0; ld_valid = 1'b0; mem_op = '0; addr = '0; flush = 1'b0;
        mem_rdata = '0; mem_rvalid = 1'b0;
        #3;
        check("rst.mem_req", {31'b0, mem_req}, 32'd0);
        check("rst.load_valid", {31'b0, load_valid}, 32'd0);
        check("rst.load_data", load_data, 32'd0);
        check("rst.load_err", {31'b0, load_err}, 32'd0);
        check("rst.mem_addr", mem_addr, 32'd0);
        check("rst.ld_ready", {31'b0, ld_ready}, 32'd1);
        check("rst.stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // Flush during the second wait cycle; response arrives three cycles later.
        next_cycle();
        ld_valid = 1'b1; mem_op = {CL_RD, 1'b0, SZ_W}; addr = 32'h800;
        saw_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            ld_valid = 1'b0; flush = (k == 2); mem_rvalid = (k == 5); mem_rdata = 32'h5A5A_5A5A;
            @(negedge clk);
            if (load_valid) saw_valid = 1'b1;
            if (k == 4) check("drain.mem_req", {31'b0, mem_req}, 32'd1);
            if (k == 5) check("drain.ready_busy", {31'b0, ld_ready}, 32'd0);
            if (k == 6) check("drain.ready_after", {31'b0, ld_ready}, 32'd1);
        end
        check("drain.no_valid", {31'b0, saw_valid}, 32'd0);

        // Flush in IDLE blocks acceptance.
        next_cycle();
        ld_valid = 1'b1; mem_op = {CL_RD, 1'b0, SZ_W}; addr = 32'h900; flush = 1'b1; mem_rvalid = 1'b0;
        @(negedge clk);
        check("idle_flush.stall", {31'b0, stall}, 32'd0);
        next_cycle();
        ld_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("idle_flush.mem_req", {31'b0, mem_req}, 32'd0);

        // Write class is ignored.
        next_cycle();
        ld_valid = 1'b1; mem_op = {CL_WR, 1'b0, SZ_W}; addr = 32'hA00;
        @(negedge clk);
        check("write.stall", {31'b0, stall}, 32'd0);
        next_cycle();
        ld_valid = 1'b0;
        @(negedge clk);
        check("write.mem_req", {31'b0, mem_req}, 32'd0);

        // Flush in RESP suppresses load_valid; data still held.
        next_cycle();
        ld_valid = 1'b1; mem_op = {CL_RD, 1'b0, SZ_W}; addr = 32'h500;
        next_cycle();
        ld_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        next_cycle();
        mem_rvalid = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("resp_flush.load_valid", {31'b0, load_valid}, 32'd0);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        check("resp_flush.ld_ready", {31'b0, ld_ready}, 32'd1);
        check("resp_flush.hold_data", load_data, 32'h1111_2222);

        // Reset asserted mid-WAIT.
        next_cycle();
        ld_valid = 1'b1; mem_op = {CL_RD, 1'b0, SZ_B}; addr = 32'h707;
        @(negedge clk);
        check("accept.stall", {31'b0, stall}, 32'd1);
        next_cycle();
        ld_valid = 1'b0;
        @(negedge clk);
        check("rstwait.mem_req_before", {31'b0, mem_req}, 32'd1);
        next_cycle();
        rst_n = 1'b0;
        #1;
        check("rstwait.mem_req", {31'b0, mem_req}, 32'd0);
        check("rstwait.mem_addr", mem_addr, 32'd0);
        check("rstwait.load_data", load_data, 32'd0);
        check("rstwait.load_valid", {31'b0, load_valid}, 32'd0);
        #2;
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            mem_rvalid = (k == 0); mem_rdata = 32'hFFFF_FFFF;
            @(negedge clk);
            if (load_valid) saw_valid = 1'b1;
        end
        mem_rvalid = 1'b0;
        check("rstwait.no_valid", {31'b0, saw_valid}, 32'd0);
        check("rstwait.mem_req_after", {31'b0, mem_req}, 32'd0);

        for (int i = 0; i < 150; i++) begin
            sz  = 2'($urandom_range(0, 2));
            uns = 1'($urandom_range(0, 1));
            rv.op = {CL_RD, uns, sz};
            rv.a  = $urandom;
            rv.rd = $urandom;
            rv.dly = ($urandom_range(0, 6) == 0) ? int'($urandom_range(MW - 1, MW + 3))
                                                 : int'($urandom_range(0, 4));
            if (ref_misalign(sz, rv.a)) begin
                rv.exp_lat = 1; rv.exp_d = '0; rv.exp_e = 1'b1; rv.exp_req = 1'b0;
            end else if (rv.dly < MW) begin
                rv.exp_lat = rv.dly + 2; rv.exp_d = ref_extract(sz, uns, rv.a, rv.rd);
                rv.exp_e = 1'b0; rv.exp_req = 1'b1;
            end else begin
                rv.exp_lat = MW + 1; rv.exp_d = '0; rv.exp_e = 1'b1; rv.exp_req = 1'b1;
            end
            apply($sformatf("rnd%0d", i), rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter MAX_WAIT, default 15; maximum cycles the block waits for memory read data before it signals an error.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ld_valid  input  1  pipeline presents a memory operation this cycle.
REQ-005 mem_op  input  5  operation code; [4:3] class (`MEM_READ/`MEM_WRITE), [2] unsigned flag, [1:0] size (`MEM_BYTE/`MEM_HALF/`MEM_WORD).
REQ-006 addr  input  32  byte address of the load.
REQ-007 flush  input  1  pipeline flush; cancels any in-flight load.
REQ-008 ld_ready  output  1  block can accept a load this cycle.
REQ-009 stall  output  1  pipeline shall hold its memory stage.
REQ-010 mem_req  output  1  read request to data memory.
REQ-011 mem_addr  output  32  word-aligned read address.
REQ-012 mem_rdata  input  32  read data from memory, little-endian lanes.
REQ-013 mem_rvalid  input  1  mem_rdata valid this cycle.
REQ-014 load_valid  output  1  one-cycle pulse; load_data/load_err final.
REQ-015 load_data  output  32  aligned, extended load result.
REQ-016 load_err  output  1  load timed out (or misaligned, see REQ-034).

Function
REQ-017 FSM states IDLE, WAIT, RESP, DRAIN; ld_ready=1 only in IDLE.
REQ-018 IDLE: ld_valid=1, mem_op[4:3]==`MEM_READ, flush=0 -> latch addr, size, unsigned flag; next state WAIT. Any other op class ignored; state stays IDLE.
REQ-019 WAIT: mem_req=1, mem_addr={latched addr[31:2],2'b00}; held stable until mem_rvalid or timeout.
REQ-020 WAIT with mem_rvalid=1 -> register extracted result into load_data; next state RESP; mem_req deasserts the following cycle.
REQ-021 RESP: load_valid=1 for exactly one cycle; next state IDLE. Accept-to-load_valid minimum latency 2 cycles (rvalid in first WAIT cycle).
REQ-022 Byte: lane addr[1:0] selects mem_rdata[8*lane+7:8*lane]. Half: addr[1] selects [15:0] or [31:16]. Word: all 32 bits.
REQ-023 Byte/half sign-extended to 32 bits when mem_op[2]=0, zero-extended when mem_op[2]=1; word ignores mem_op[2].
REQ-024 Wait counter 0 on WAIT entry, +1 each WAIT cycle without mem_rvalid; at MAX_WAIT -> load_data=0, load_err=1, state RESP, mem_req deasserted.
REQ-025 mem_rvalid on the same cycle the counter reaches MAX_WAIT: data wins, load_err=0.
REQ-026 flush in WAIT -> state DRAIN; no load_valid for that load; mem_req stays high until mem_rvalid or timeout, then IDLE.
REQ-027 flush in IDLE blocks acceptance that cycle; flush in RESP suppresses load_valid, next state IDLE.
REQ-028 mem_rvalid in IDLE or RESP ignored.
REQ-029 stall = (state != IDLE) OR (IDLE and a load is accepted this cycle).
REQ-030 load_data, load_err hold their value outside RESP; only load_valid qualifies them.

Reset
REQ-031 rst_n low -> state IDLE, counter 0, mem_req 0, mem_addr 0, load_valid 0, load_data 0, load_err 0, latched fields 0; immediate, asynchronous.
REQ-032 Reset mid-WAIT or DRAIN abandons the load; mem_rvalid after reset release ignored (state IDLE).

Configuration
REQ-033 Macro LOAD_MISALIGN_CHK_EN selects misalignment checking.
REQ-034 Defined: half with addr[0]=1 or word with addr[1:0]!=0 -> no mem_req; next state RESP with load_data=0, load_err=1.
REQ-035 Undefined: no check; half ignores addr[0], word ignores addr[1:0]; load_err only on timeout.

Verification
REQ-036 LB signed, addr=0x103, mem_rdata=0x80FF_1234 in first WAIT cycle -> load_valid 2 cycles after accept, load_data=0xFFFF_FF80, mem_addr=0x100.
REQ-037 LHU, addr=0x202, mem_rdata=0x8001_7FFF -> load_data=0x0000_8001, load_err=0.
REQ-038 LW, mem_rvalid withheld MAX_WAIT cycles -> load_valid with load_err=1, load_data=0, mem_req low after.
REQ-039 LW accepted, flush in 2nd WAIT cycle, mem_rvalid 3 cycles later -> no load_valid, ld_ready=1 the cycle after rvalid.
REQ-040 LH addr=0x301 -> with LOAD_MISALIGN_CHK_EN: no mem_req, load_err=1; without: mem_addr=0x300, lower half returned.
REQ-041 rst_n asserted during WAIT -> all outputs 0 at once; late mem_rvalid produces no load_valid.
